// File: rtl/dispense_pkg.sv
// rtl/dispense_pkg.sv - shared state type, default servo timing and width helper for the dispense scheduler
package dispense_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    CLOSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Defaults assume a 100 kHz tick: 20 ms frame, 2.0 ms open pulse, 1.0 ms closed pulse.
  localparam int DEF_PERIOD_TICKS = 2000;
  localparam int DEF_OPEN_WIDTH   = 200;
  localparam int DEF_CLOSE_WIDTH  = 100;
  localparam int DEF_HOLD_PERIODS = 50;
  localparam int DEF_CNT_W        = 12;

  function automatic int slot_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dispense_rr_arb.sv
// rtl/dispense_rr_arb.sv - combinational round-robin pick: lowest requesting index at or above ptr_i, wrapping
module dispense_rr_arb
  import dispense_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int SW        = slot_w(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0] req_i,
  input  logic [SW-1:0]        ptr_i,
  output logic [SW-1:0]        win_o,
  output logic                 valid_o
);

  always_comb begin
    int             j;
    logic [SW-1:0]  idx;
    logic           found;
    j       = 0;
    idx     = '0;
    found   = 1'b0;
    win_o   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      j = int'(ptr_i) + i;
      if (j >= NUM_SLOTS) j = j - NUM_SLOTS;
      idx = SW'(j);
      if (!found && req_i[idx]) begin
        found = 1'b1;
        win_o = idx;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/dispense_pwm_sched.sv
// rtl/dispense_pwm_sched.sv - round-robin servo gate sequencer on one shared PWM frame engine (optional DISPENSE_ABORT_EN)
module dispense_pwm_sched
  import dispense_pkg::*;
#(
  parameter int NUM_SLOTS    = 4,
  parameter int PERIOD_TICKS = DEF_PERIOD_TICKS,
  parameter int OPEN_WIDTH   = DEF_OPEN_WIDTH,
  parameter int CLOSE_WIDTH  = DEF_CLOSE_WIDTH,
  parameter int HOLD_PERIODS = DEF_HOLD_PERIODS,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick_i,
  input  logic [NUM_SLOTS-1:0]          req_i,
`ifdef DISPENSE_ABORT_EN
  input  logic                          abort_i,
`endif
  output logic [NUM_SLOTS-1:0]          grant_o,
  output logic [NUM_SLOTS-1:0]          pwm_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [$clog2(NUM_SLOTS)-1:0]  slot_o
);

  localparam int SW = slot_w(NUM_SLOTS);
  localparam int HW = $clog2(HOLD_PERIODS + 1);

  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(PERIOD_TICKS - 1);
  localparam logic [CNT_W-1:0] OPEN_HI    = CNT_W'(OPEN_WIDTH);
  localparam logic [CNT_W-1:0] CLOSE_HI   = CNT_W'(CLOSE_WIDTH);
  localparam logic [HW-1:0]    HOLD_LAST  = HW'(HOLD_PERIODS - 1);
  localparam logic [SW-1:0]    SLOT_LAST  = SW'(NUM_SLOTS - 1);

  state_t                 state_q;
  logic [CNT_W-1:0]       frame_q, frame_d, hi_cur;
  logic [HW-1:0]          hold_q;
  logic [SW-1:0]          ptr_q, slot_q, win_idx;
  logic                   win_valid;
  logic [NUM_SLOTS-1:0]   grant_q, pwm_q, win_mask;
  logic                   busy_q, done_q;
  logic                   wrap, last_frame, abort_req;

  dispense_rr_arb #(
    .NUM_SLOTS (NUM_SLOTS),
    .SW        (SW)
  ) u_arb (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .win_o   (win_idx),
    .valid_o (win_valid)
  );

  assign win_mask   = NUM_SLOTS'(1) << win_idx;
  assign wrap       = tick_i && (frame_q == FRAME_LAST);
  assign frame_d    = !tick_i ? frame_q : (wrap ? '0 : frame_q + CNT_W'(1));
  assign last_frame = (hold_q == HOLD_LAST);
  assign hi_cur     = (state_q == OPEN) ? OPEN_HI : CLOSE_HI;

`ifdef DISPENSE_ABORT_EN
  // Abort is remembered until the frame wrap so the open pulse in flight is never cut short.
  logic abort_q;
  always_ff @(posedge clk) begin
    if (rst || state_q != OPEN) abort_q <= 1'b0;
    else if (abort_i)           abort_q <= 1'b1;
  end
  assign abort_req = abort_q | abort_i;
`else
  assign abort_req = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      frame_q <= '0;
      hold_q  <= '0;
      ptr_q   <= '0;
      slot_q  <= '0;
      grant_q <= '0;
      pwm_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_valid) begin
            state_q <= OPEN;
            slot_q  <= win_idx;
            grant_q <= win_mask;
            frame_q <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b1;
            pwm_q   <= (OPEN_HI != '0) ? win_mask : '0;
          end
        end
        OPEN, CLOSE: begin
          frame_q <= frame_d;
          if (wrap && state_q == OPEN && (last_frame || abort_req)) begin
            state_q <= CLOSE;
            hold_q  <= '0;
            pwm_q   <= (CLOSE_HI != '0) ? grant_q : '0;
          end else if (wrap && state_q == CLOSE && last_frame) begin
            state_q <= DONE;
            hold_q  <= '0;
            grant_q <= '0;
            pwm_q   <= '0;
            done_q  <= 1'b1;
          end else begin
            if (wrap) hold_q <= hold_q + HW'(1);
            pwm_q <= (frame_d < hi_cur) ? grant_q : '0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ptr_q   <= (slot_q == SLOT_LAST) ? '0 : slot_q + SW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_o = grant_q;
  assign pwm_o   = pwm_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign slot_o  = slot_q;

endmodule

// File: tb/tb_dispense_pwm_sched.sv
// tb/tb_dispense_pwm_sched.sv - vector table plus scoreboard bench for dispense_pwm_sched (DISPENSE_ABORT_EN aware)
module tb_dispense_pwm_sched;

  localparam int P  = 10;
  localparam int OW = 4;
  localparam int CW = 2;
  localparam int H  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_i = 1'b0;
  logic [3:0] req_i = 4'b0;
  logic [3:0] grant_o, pwm_o;
  logic       busy_o, done_o;
  logic [1:0] slot_o;
`ifdef DISPENSE_ABORT_EN
  logic       abort_i = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int grant_t  = 0;
  logic [3:0] prev_grant = 4'b0;

  typedef struct {
    int slot;
    int len;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic [3:0] req;
    int         slot;
  } vec_t;
  vec_t vecs[8];

  dispense_pwm_sched #(
    .NUM_SLOTS    (4),
    .PERIOD_TICKS (P),
    .OPEN_WIDTH   (OW),
    .CLOSE_WIDTH  (CW),
    .HOLD_PERIODS (H),
    .CNT_W        (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tick_i  (tick_i),
    .req_i   (req_i),
`ifdef DISPENSE_ABORT_EN
    .abort_i (abort_i),
`endif
    .grant_o (grant_o),
    .pwm_o   (pwm_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .slot_o  (slot_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // {grant, pwm, busy, done, slot} expected kk cycles after the grant becomes visible
  function automatic logic [11:0] exp_vec(input int kk, input int s, input int div, input int open_fr);
    logic [3:0] m;
    int t, fr, c, hi, tot;
    m   = 4'(1 << s);
    tot = (open_fr + H) * P * div;
    if (kk < tot) begin
      t  = kk / div;
      fr = t / P;
      c  = t % P;
      hi = (fr < open_fr) ? OW : CW;
      return {m, (c < hi) ? m : 4'b0, 1'b1, 1'b0, 2'(s)};
    end else if (kk == tot) begin
      return {4'b0, 4'b0, 1'b1, 1'b1, 2'(s)};
    end
    return {4'b0, 4'b0, 1'b0, 1'b0, 2'(s)};
  endfunction

  always @(negedge clk) begin
    sb_t e;
    if (grant_o != 4'b0 && prev_grant == 4'b0) grant_t = cyc;
    if (done_o) begin
      if (sb.size() == 0) begin
        chk("done_unexpected", 32'(done_o), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_slot", 32'(slot_o), 32'(e.slot));
        chk("sb_len", 32'(cyc - grant_t), 32'(e.len));
      end
    end
    prev_grant = grant_o;
  end

  task automatic run_dispense(input logic [3:0] req, input int s, input int div, input int hold_k,
                              input int abort_k, input int open_fr, input string name);
    int  tot;
    sb_t e;
    tot    = (open_fr + H) * P * div;
    e.slot = s;
    e.len  = tot;
    @(negedge clk);
    req_i  = req;
    tick_i = (div == 1);
    sb.push_back(e);
    for (int k = 0; k <= tot + 3; k++) begin
      @(negedge clk);
      req_i  = (k < hold_k) ? req : 4'b0;
      tick_i = (k % div) == (div - 1);
`ifdef DISPENSE_ABORT_EN
      abort_i = (k == abort_k);
`endif
      chk(name, 32'({grant_o, pwm_o, busy_o, done_o, slot_o}), 32'(exp_vec(k, s, div, open_fr)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{4'b0001, 0};
    vecs[1] = '{4'b1111, 1};
    vecs[2] = '{4'b0011, 0};
    vecs[3] = '{4'b1000, 3};
    vecs[4] = '{4'b1100, 2};
    vecs[5] = '{4'b0110, 1};
    vecs[6] = '{4'b0101, 2};
    vecs[7] = '{4'b0001, 0};

    repeat (3) @(negedge clk);
    chk("reset_state", 32'({grant_o, pwm_o, busy_o, done_o, slot_o}), 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) run_dispense(vecs[i].req, vecs[i].slot, 1, 0, -1, H, "table");

    // Reset during OPEN frame 0 tick 5: immediate abort, no done, pointer back to 0
    @(negedge clk);
    req_i  = 4'b0001;
    tick_i = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      req_i = 4'b0;
      chk("rst_pre", 32'({grant_o, pwm_o, busy_o, done_o, slot_o}), 32'(exp_vec(k, 0, 1, H)));
      if (k == 5) rst = 1'b1;
    end
    @(negedge clk);
    chk("rst_abort", 32'({grant_o, pwm_o, busy_o, done_o, slot_o}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_idle", 32'({grant_o, pwm_o, busy_o, done_o, slot_o}), 32'd0);
    run_dispense(4'b0011, 0, 1, 0, -1, H, "rst_ptr");
    run_dispense(4'b0100, 2, 1, 0, -1, H, "rst_next");

    // Contention with 1010 held from pointer 0: slot 1, then 3, then 1
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    req_i  = 4'b1010;
    tick_i = 1'b1;
    begin
      sb_t e;
      e.len = (H + H) * P;
      e.slot = 1; sb.push_back(e);
      e.slot = 3; sb.push_back(e);
      e.slot = 1; sb.push_back(e);
    end
    for (int k = 0; k < 128; k++) begin
      int seg;
      @(negedge clk);
      req_i = (k < 84) ? 4'b1010 : 4'b0;
      seg   = (k < 84) ? k / 42 : 2;
      chk("contend", 32'({grant_o, pwm_o, busy_o, done_o, slot_o}),
          32'(exp_vec(k - 42 * seg, (seg == 1) ? 3 : 1, 1, H)));
    end

    run_dispense(4'b0001, 0, 3, 0, -1, H, "tick_div3");
    run_dispense(4'b0001, 0, 1, 25, -1, H, "req_drop");
`ifdef DISPENSE_ABORT_EN
    run_dispense(4'b0010, 1, 1, 0, 3, 1, "abort");
`endif

    @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
